aes_pipe_buffer: RTL
====================

AES_PIPE_BUFFER -- requirements
Module: aes_pipe_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 128: width of each data field.
REQ-002 SHALL have parameter DEPTH, default 4: entry count; legal values are powers of two, DEPTH >= 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port i_valid, input, 1 bit: upstream entry present.
REQ-006 SHALL have port o_ready, output, 1 bit: buffer can accept an entry this cycle.
REQ-007 SHALL have ports i_plain_text, i_aad, i_instance_size, inputs, DATA_W bits each: entry payload.
REQ-008 SHALL have port i_last, input, 1 bit: final block of a message.
REQ-009 SHALL have port i_flush, input, 1 bit: discard all stored entries.
REQ-010 SHALL have port o_valid, output, 1 bit: head entry present.
REQ-011 SHALL have port i_ready, input, 1 bit: downstream accepts the head entry.
REQ-012 SHALL have ports o_plain_text, o_aad, o_instance_size, outputs, DATA_W bits each: head payload.
REQ-013 SHALL have port o_last, output, 1 bit: head entry's last flag.
REQ-014 SHALL have port o_count, output, $clog2(DEPTH+1) bits: current occupancy.
REQ-015 SHALL have ports o_full and o_empty, outputs, 1 bit each: count==DEPTH and count==0 respectively.

Function
REQ-016 SHALL push when i_valid && o_ready, and pop when o_valid && i_ready.
REQ-017 SHALL drive o_ready = !o_full combinationally from registered state, with no dependence on i_ready.
REQ-018 SHALL give one-cycle latency: an entry pushed into an empty buffer at edge N is presented with o_valid=1 after edge N.
REQ-019 SHALL preserve strict FIFO order for all four payload fields together.
REQ-020 SHALL hold o_* payload stable while o_valid && !i_ready.
REQ-021 SHALL, on a simultaneous push and pop, keep the count unchanged and advance both pointers.
REQ-022 SHALL, when full, refuse pushes (o_ready=0) but still allow a pop; the freed slot becomes pushable the following cycle.
REQ-023 SHALL wrap read and write pointers modulo DEPTH without a gap entry.
REQ-024 SHALL keep o_count as a registered counter: +1 on push only, -1 on pop only, otherwise unchanged; it never exceeds DEPTH or drops below 0.
REQ-025 SHALL, on i_flush=1, reset pointers and count to 0 at the next edge, with o_valid=0 after that edge.
REQ-026 SHALL give i_flush priority: any push or pop in the flush cycle is ignored.
REQ-027 SHALL never update state when a pop is attempted while empty (o_valid=0).
REQ-028 SHALL drive o_plain_text, o_aad and o_instance_size from the head storage slot; their value is don't-care while o_valid=0.

Reset
REQ-029 SHALL, while rst_n=0, immediately force pointers=0, count=0, o_valid=0, o_empty=1, o_full=0, o_ready=1 and o_last=0.
REQ-030 SHALL NOT require storage array reset; payload outputs read 0 after reset only if the implementation resets storage, and benches do not check them.
REQ-031 SHALL, on reset asserted mid-transfer, discard all entries, and the first edge after deassertion accepts new pushes.

Structure
REQ-032 SHALL take from shared package aes_pkg: constant AES_BLK_W=128 and packed struct aes_entry_t {plain_text, aad, instance_size, last}, with DATA_W defaulting to AES_BLK_W.
REQ-033 SHALL store entries as one aes_entry_t-style array of DEPTH words.
REQ-034 SHALL use one natural sub-module, aes_wrap_ptr: a modulo-DEPTH pointer with inc, clear and async reset, instantiated twice (read and write).

Verification
REQ-035 SHALL cover reset then single push of plain_text=0x00112233...FF with last=1 -> o_valid=1 one cycle later, same payload, o_count=1.
REQ-036 SHALL cover pushing 4 entries with DEPTH=4 and i_ready=0 -> o_full=1, o_ready=0; a 5th push is ignored and o_count stays 4.
REQ-037 SHALL cover continuous push and pop at count=2 for 10 cycles -> o_count stays 2, output order matches input order, pointers wrap.
REQ-038 SHALL cover i_flush together with i_valid at count=3 -> o_count=0, o_empty=1 next cycle, and the flushed-cycle entry is never output.
REQ-039 SHALL cover rst_n pulsed low mid-cycle at count=2 -> o_valid=0 and o_count=0 immediately, without waiting for a clock edge.
REQ-040 SHALL cover stalling i_ready=0 for 5 cycles with o_valid=1 -> o_* payload and o_last unchanged throughout.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES datapath definitions: block width and the buffered entry layout.
package aes_pkg;

  localparam int unsigned AES_BLK_W = 128;

  // One buffered AES work item: payload fields plus the end-of-message flag.
  typedef struct packed {
    logic [AES_BLK_W-1:0] plain_text;
    logic [AES_BLK_W-1:0] aad;
    logic [AES_BLK_W-1:0] instance_size;
    logic                 last;
  } aes_entry_t;

endpackage : aes_pkg

// File: rtl/aes_pipe_buffer_if.sv
// Valid/ready bus for aes_pipe_buffer.
//   slave  : the buffer side (takes i_* from upstream/downstream, drives o_*)
//   master : the environment side (drives i_*, observes o_*)
// Upstream: i_valid/o_ready, i_plain_text/i_aad/i_instance_size/i_last.
// Downstream: o_valid/i_ready, o_plain_text/o_aad/o_instance_size/o_last.
// Control/status: i_flush, o_count, o_full, o_empty.
interface aes_pipe_buffer_if
  import aes_pkg::*;
#(
  parameter int unsigned DATA_W = AES_BLK_W,
  parameter int unsigned DEPTH  = 4
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic              i_valid;
  logic              o_ready;
  logic [DATA_W-1:0] i_plain_text;
  logic [DATA_W-1:0] i_aad;
  logic [DATA_W-1:0] i_instance_size;
  logic              i_last;
  logic              i_flush;

  logic              o_valid;
  logic              i_ready;
  logic [DATA_W-1:0] o_plain_text;
  logic [DATA_W-1:0] o_aad;
  logic [DATA_W-1:0] o_instance_size;
  logic              o_last;

  logic [CNT_W-1:0]  o_count;
  logic              o_full;
  logic              o_empty;

  modport slave (
    input  i_valid, i_plain_text, i_aad, i_instance_size, i_last, i_flush, i_ready,
    output o_ready, o_valid, o_plain_text, o_aad, o_instance_size, o_last,
           o_count, o_full, o_empty
  );

  modport master (
    output i_valid, i_plain_text, i_aad, i_instance_size, i_last, i_flush, i_ready,
    input  o_ready, o_valid, o_plain_text, o_aad, o_instance_size, o_last,
           o_count, o_full, o_empty
  );

endinterface : aes_pipe_buffer_if

// File: rtl/aes_wrap_ptr.sv
// Modulo-DEPTH pointer with synchronous clear and increment.
// Ports: clk, rst_n (async active-low), clear_i (to 0, wins over inc_i),
//        inc_i (advance by one, wrapping), ptr_o (registered pointer).
module aes_wrap_ptr #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear_i,
  input  logic                     inc_i,
  output logic [$clog2(DEPTH)-1:0] ptr_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  // DEPTH is a power of two, so plain binary overflow is the modulo wrap.
  always_comb begin
    ptr_d = ptr_q;
    if (clear_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule : aes_wrap_ptr

// File: rtl/aes_pipe_buffer.sv
// DEPTH-entry FIFO for AES work items (plain_text, aad, instance_size, last).
// Ports: clk, rst_n (async active-low), bus (aes_pipe_buffer_if slave).
// Head entry is shown combinationally from storage, giving one-cycle latency
// from push to o_valid. Flush has priority over push and pop.
module aes_pipe_buffer
  import aes_pkg::*;
#(
  parameter int unsigned DATA_W = AES_BLK_W,
  parameter int unsigned DEPTH  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  aes_pipe_buffer_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  // Same layout as aes_entry_t, sized by DATA_W.
  typedef struct packed {
    logic [DATA_W-1:0] plain_text;
    logic [DATA_W-1:0] aad;
    logic [DATA_W-1:0] instance_size;
    logic              last;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           head_c;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             full_c;
  logic             empty_c;
  logic             push_c;
  logic             pop_c;

  // Status from registered occupancy only.
  assign full_c  = (count_q == CNT_W'(DEPTH));
  assign empty_c = (count_q == '0);

  // Handshakes, both suppressed during a flush.
  assign push_c = bus.i_valid && !full_c && !bus.i_flush;
  assign pop_c  = !empty_c && bus.i_ready && !bus.i_flush;

  // Occupancy next state.
  always_comb begin
    count_d = count_q;
    if (bus.i_flush) begin
      count_d = '0;
    end else if (push_c && !pop_c) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop_c && !push_c) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[wr_ptr].plain_text    <= bus.i_plain_text;
      mem_q[wr_ptr].aad           <= bus.i_aad;
      mem_q[wr_ptr].instance_size <= bus.i_instance_size;
      mem_q[wr_ptr].last          <= bus.i_last;
    end
  end

  aes_wrap_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (bus.i_flush),
    .inc_i   (pop_c),
    .ptr_o   (rd_ptr)
  );

  aes_wrap_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (bus.i_flush),
    .inc_i   (push_c),
    .ptr_o   (wr_ptr)
  );

  assign head_c = mem_q[rd_ptr];

  assign bus.o_ready         = !full_c;
  assign bus.o_valid         = !empty_c;
  assign bus.o_full          = full_c;
  assign bus.o_empty         = empty_c;
  assign bus.o_count         = count_q;
  assign bus.o_plain_text    = head_c.plain_text;
  assign bus.o_aad           = head_c.aad;
  assign bus.o_instance_size = head_c.instance_size;
  // Gated so it reads 0 whenever nothing is stored, including under reset.
  assign bus.o_last          = head_c.last && !empty_c;

endmodule : aes_pipe_buffer
